// File: rtl/pe_window_feeder.sv
// Window feeder for the convolution PE: latches a packed 3x3 window and
// streams it tap by tap, each pixel paired with its filter weight.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no window in flight; ready to accept; weight writes allowed
// STREAM | issuing tap k of the latched window; ready again on last tap
module pe_window_feeder #(
   parameter int DATA_W = 8,
   parameter int TAPS   = 9,
   parameter int IDX_W  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wgt_wr_en,
   input  logic [IDX_W-1:0]       wgt_addr,
   input  logic [DATA_W-1:0]      wgt_data,
   input  logic                   win_valid,
   output logic                   win_ready,
   input  logic [TAPS*DATA_W-1:0] win_data,
   output logic [DATA_W-1:0]      pe_in,
   output logic [DATA_W-1:0]      pe_filter,
   output logic                   pe_en,
   output logic                   pe_start,
   output logic                   pe_last,
   output logic                   busy,
   output logic                   wgt_err,
   output logic [15:0]            win_cnt
);

   typedef enum logic {IDLE, STREAM} state_t;

   localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAPS - 1);
   localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        k_q, k_d;
   logic                    at_last;
   logic                    accept;
   logic                    wgt_in_range;
   logic                    wgt_we;
   logic                    wgt_drop;
   logic [TAPS*DATA_W-1:0]  win_q;
   logic [DATA_W-1:0]       wgt_q [TAPS];
   logic [DATA_W-1:0]       tap_pix;
   logic [DATA_W-1:0]       tap_wgt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   always_comb begin
      at_last   = (state_q == STREAM) && (k_q == LAST_TAP);
      win_ready = (state_q == IDLE) || at_last;
      accept    = win_valid && win_ready;
      state_d   = state_q;
      k_d       = k_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = STREAM;
               k_d     = '0;
            end
         end
         STREAM: begin
            if (k_q == LAST_TAP) begin
               k_d = '0;
               if (!accept) state_d = IDLE;
            end else begin
               k_d = k_q + ONE;
            end
         end
         default: begin
            state_d = IDLE;
            k_d     = '0;
         end
      endcase
   end

   assign busy = (state_q == STREAM);

   // Weights are frozen from the accept edge through the last tap, so a
   // window always sees a single consistent filter.
   always_comb begin
      wgt_in_range = (wgt_addr <= LAST_TAP);
      wgt_we       = wgt_wr_en && wgt_in_range && (state_q == IDLE) && !accept;
      wgt_drop     = wgt_wr_en && wgt_in_range && ((state_q == STREAM) || accept);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < TAPS; i++) wgt_q[i] <= '0;
      end else begin
         for (int i = 0; i < TAPS; i++) begin
            if (wgt_we && (wgt_addr == IDX_W'(i))) wgt_q[i] <= wgt_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wgt_err <= 1'b0;
      end else if (wgt_drop) begin
         wgt_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_q <= '0;
      end else if (accept) begin
         win_q <= win_data;
      end
   end

   always_comb begin
      tap_pix = '0;
      tap_wgt = '0;
      for (int i = 0; i < TAPS; i++) begin
         if (k_q == IDX_W'(i)) begin
            tap_pix = win_q[i*DATA_W +: DATA_W];
            tap_wgt = wgt_q[i];
         end
      end
   end

   // On a no-bubble handover win_q is reloaded at the same edge that issues
   // the last tap; the issue path still sees the old window.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pe_in     <= '0;
         pe_filter <= '0;
         pe_en     <= 1'b0;
         pe_start  <= 1'b0;
         pe_last   <= 1'b0;
      end else if (state_q == STREAM) begin
         pe_in     <= tap_pix;
         pe_filter <= tap_wgt;
         pe_en     <= 1'b1;
         pe_start  <= (k_q == '0);
         pe_last   <= (k_q == LAST_TAP);
      end else begin
         pe_in     <= '0;
         pe_filter <= '0;
         pe_en     <= 1'b0;
         pe_start  <= 1'b0;
         pe_last   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_cnt <= '0;
      end else if (at_last) begin
         win_cnt <= win_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_pe_window_feeder.sv
// Directed bench for pe_window_feeder: a negedge monitor records every issued
// tap, and the stimulus checks the recorded stream against hand-computed values.
module tb_pe_window_feeder;

   localparam int DW = 8;
   localparam int TP = 9;
   localparam int IW = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             wgt_wr_en = 1'b0;
   logic [IW-1:0]    wgt_addr = '0;
   logic [DW-1:0]    wgt_data = '0;
   logic             win_valid = 1'b0;
   logic             win_ready;
   logic [TP*DW-1:0] win_data = '0;
   logic [DW-1:0]    pe_in;
   logic [DW-1:0]    pe_filter;
   logic             pe_en;
   logic             pe_start;
   logic             pe_last;
   logic             busy;
   logic             wgt_err;
   logic [15:0]      win_cnt;

   pe_window_feeder #(.DATA_W(DW), .TAPS(TP), .IDX_W(IW)) dut (
      .clk(clk), .rst(rst),
      .wgt_wr_en(wgt_wr_en), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
      .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
      .pe_in(pe_in), .pe_filter(pe_filter), .pe_en(pe_en),
      .pe_start(pe_start), .pe_last(pe_last), .busy(busy),
      .wgt_err(wgt_err), .win_cnt(win_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int idle_bad = 0;
   logic [DW-1:0] q_in[$];
   logic [DW-1:0] q_f[$];
   logic          q_s[$];
   logic          q_l[$];
   int            q_c[$];

   always @(negedge clk) begin
      cyc++;
      if (rst && pe_en) begin
         q_in.push_back(pe_in);
         q_f.push_back(pe_filter);
         q_s.push_back(pe_start);
         q_l.push_back(pe_last);
         q_c.push_back(cyc);
      end else if (rst && ((pe_in != '0) || (pe_filter != '0) || pe_start || pe_last)) begin
         idle_bad++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_q();
      q_in.delete(); q_f.delete(); q_s.delete(); q_l.delete(); q_c.delete();
   endtask

   task automatic wr_wgt(input int a, input int d);
      @(negedge clk);
      wgt_wr_en = 1'b1;
      wgt_addr  = IW'(a);
      wgt_data  = DW'(d);
      @(negedge clk);
      wgt_wr_en = 1'b0;
   endtask

   // Present a window and return at the negedge after its accept edge.
   task automatic push_window(input logic [TP*DW-1:0] d);
      int n = 0;
      win_data  = d;
      win_valid = 1'b1;
      while (!win_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("ready_timeout", 32'(n < 40), 32'd1);
      @(negedge clk);
   endtask

   task automatic wait_taps(input int n, input int budget);
      int c = 0;
      while (q_in.size() < n && c < budget) begin
         @(negedge clk);
         #1;
         c++;
      end
      chk("tap_timeout", 32'(q_in.size() >= n), 32'd1);
   endtask

   function automatic logic [TP*DW-1:0] fill(input int v);
      logic [TP*DW-1:0] r;
      for (int i = 0; i < TP; i++) r[i*DW +: DW] = DW'(v);
      return r;
   endfunction

   logic [TP*DW-1:0] wbuf;
   int vals [4] = '{10, 5, 2, 20};
   int exp_cnt = 0;

   initial begin
      #200000;
      $display("FAIL watchdog");
      $fatal(1);
   end

   initial begin
      // 1: reset and idle
      repeat (2) @(negedge clk);
      chk("rst_pe_en", 32'(pe_en), 0);
      chk("rst_pe_in", 32'(pe_in), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_win_cnt", 32'(win_cnt), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(win_ready), 1);
      repeat (3) @(negedge clk);
      chk("idle_pe_en", 32'(pe_en), 0);

      // 2: single window, weights and pixels all 10
      for (int i = 0; i < TP; i++) wr_wgt(i, 10);
      clear_q();
      push_window(fill(10));
      win_valid = 1'b0;
      chk("busy_after_accept", 32'(busy), 1);
      chk("ready_mid_stream", 32'(win_ready), 0);
      wait_taps(TP, 30);
      repeat (3) @(negedge clk);
      exp_cnt++;
      chk("single_len", q_in.size(), TP);
      for (int i = 0; i < TP; i++) begin
         chk("single_in", 32'(q_in[i]), 10);
         chk("single_f", 32'(q_f[i]), 10);
         chk("single_start", 32'(q_s[i]), 32'(i == 0));
         chk("single_last", 32'(q_l[i]), 32'(i == TP - 1));
      end
      chk("single_en_off", 32'(pe_en), 0);
      chk("single_cnt", 32'(win_cnt), 32'(exp_cnt));

      // 3: back-to-back windows with win_valid held high
      clear_q();
      for (int w = 0; w < 4; w++) push_window(fill(vals[w]));
      win_valid = 1'b0;
      wait_taps(4 * TP, 60);
      repeat (3) @(negedge clk);
      exp_cnt += 4;
      chk("b2b_len", q_in.size(), 4 * TP);
      for (int i = 0; i < 4 * TP; i++) begin
         chk("b2b_contig", q_c[i], q_c[0] + i);
         chk("b2b_in", 32'(q_in[i]), vals[i / TP]);
         chk("b2b_start", 32'(q_s[i]), 32'(i % TP == 0));
         chk("b2b_last", 32'(q_l[i]), 32'(i % TP == TP - 1));
      end
      chk("b2b_cnt", 32'(win_cnt), 32'(exp_cnt));

      // 4: tap ordering
      for (int i = 0; i < TP; i++) wr_wgt(i, i + 1);
      for (int i = 0; i < TP; i++) wbuf[i*DW +: DW] = DW'(16 * i);
      clear_q();
      push_window(wbuf);
      win_valid = 1'b0;
      wait_taps(TP, 30);
      exp_cnt++;
      for (int i = 0; i < TP; i++) begin
         chk("order_in", 32'(q_in[i]), 16 * i);
         chk("order_f", 32'(q_f[i]), i + 1);
      end

      // 5: weight write while busy is dropped
      repeat (3) @(negedge clk);
      clear_q();
      push_window(fill(7));
      wgt_wr_en = 1'b1;
      wgt_addr  = 4'd3;
      wgt_data  = 8'd99;
      @(negedge clk);
      wgt_wr_en = 1'b0;
      chk("busy_wr_err", 32'(wgt_err), 1);
      push_window(fill(8));
      win_valid = 1'b0;
      wait_taps(2 * TP, 40);
      repeat (3) @(negedge clk);
      exp_cnt += 2;
      chk("drop_w3_a", 32'(q_f[3]), 4);
      chk("drop_w3_b", 32'(q_f[TP + 3]), 4);
      chk("drop_in_b", 32'(q_in[TP + 3]), 8);
      wr_wgt(3, 99);
      clear_q();
      push_window(fill(1));
      win_valid = 1'b0;
      wait_taps(TP, 30);
      exp_cnt++;
      chk("idle_wr_w3", 32'(q_f[3]), 99);
      chk("idle_wr_w4", 32'(q_f[4]), 5);
      chk("err_sticky", 32'(wgt_err), 1);
      repeat (3) @(negedge clk);
      chk("cnt_before_abort", 32'(win_cnt), 32'(exp_cnt));

      // 6: reset at tap 4
      clear_q();
      push_window(fill(3));
      win_valid = 1'b0;
      wait_taps(5, 30);
      rst = 1'b0;
      #1;
      chk("abort_pe_en", 32'(pe_en), 0);
      chk("abort_pe_in", 32'(pe_in), 0);
      chk("abort_pe_f", 32'(pe_filter), 0);
      chk("abort_cnt", 32'(win_cnt), 0);
      chk("abort_err", 32'(wgt_err), 0);
      chk("abort_no_last", 32'(q_l[4]), 0);
      @(negedge clk);
      rst = 1'b1;
      clear_q();
      wr_wgt(12, 55);
      chk("oob_no_err", 32'(wgt_err), 0);
      for (int i = 0; i < TP; i++) wr_wgt(i, 2 * i + 1);
      push_window(fill(6));
      win_valid = 1'b0;
      wait_taps(TP, 30);
      repeat (3) @(negedge clk);
      chk("post_rst_len", q_in.size(), TP);
      chk("post_rst_f8", 32'(q_f[8]), 17);
      chk("post_rst_last", 32'(q_l[8]), 1);
      chk("post_rst_cnt", 32'(win_cnt), 1);

      // write in the accept cycle is dropped
      clear_q();
      @(negedge clk);
      win_data  = fill(4);
      win_valid = 1'b1;
      wgt_wr_en = 1'b1;
      wgt_addr  = 4'd0;
      wgt_data  = 8'd77;
      @(negedge clk);
      win_valid = 1'b0;
      wgt_wr_en = 1'b0;
      chk("acc_wr_err", 32'(wgt_err), 1);
      wait_taps(TP, 30);
      chk("acc_wr_w0", 32'(q_f[0]), 1);
      repeat (3) @(negedge clk);
      chk("idle_outputs_zero", idle_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
